ls_sequencer: RTL

//  Multicycle load/store sequencer between control unit and word-wide data memory.

---
 rtl/ls_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ls_sequencer.sv
// Multicycle load/store sequencer: issues word accesses to a data memory, waits out
// the read latency, and read-modify-writes sub-word stores.
module ls_sequencer #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_size;
    logic [1:0]       r_lane;
    logic             r_is_store;
    logic [15:0]      r_sdata;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_load_data;
    logic             r_mem_wr;
    logic             r_done;
    logic             r_misaligned;

    logic             w_misaligned;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_merged;
    logic [31:0]      w_load_lane;

    // Lane extraction and store merge work on the latched lane, never on live inputs.
    always_comb begin
        w_misaligned = (size == 2'b10 && addr[0]) ||
                       (size == 2'b11 && addr[1:0] != 2'b00);
        w_byte       = mem_rdata[7:0];
        w_half       = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_merged     = mem_rdata;
        w_load_lane  = mem_rdata;
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (r_size)
            2'b01: begin
                w_load_lane = {24'd0, w_byte};
                case (r_lane)
                    2'd0:    w_merged[7:0]   = r_sdata[7:0];
                    2'd1:    w_merged[15:8]  = r_sdata[7:0];
                    2'd2:    w_merged[23:16] = r_sdata[7:0];
                    default: w_merged[31:24] = r_sdata[7:0];
                endcase
            end
            2'b10: begin
                w_load_lane = {16'd0, w_half};
                if (r_lane[1]) w_merged[31:16] = r_sdata;
                else           w_merged[15:0]  = r_sdata;
            end
            default: ;
        endcase
    end

    // Word stores skip the read phase entirely; sub-word stores fetch, merge, then write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
            r_is_store   <= 1'b0;
            r_sdata      <= 16'd0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_load_data  <= 32'd0;
            r_mem_wr     <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_mem_wr     <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && size != 2'b00) begin
                        r_size     <= size;
                        r_lane     <= addr[1:0];
                        r_is_store <= is_store;
                        r_sdata    <= store_data[15:0];
                        r_mem_addr <= {addr[31:2], 2'b00};
                        r_cnt      <= '0;
                        if (w_misaligned) begin
                            r_state      <= S_FAULT;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else if (is_store && size == 2'b11) begin
                            r_state     <= S_WRITE;
                            r_mem_wr    <= 1'b1;
                            r_mem_wdata <= store_data;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_cnt == CNT_LAST) r_state <= S_CAPTURE;
                    else                   r_cnt   <= r_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    if (r_is_store) begin
                        r_mem_wdata <= w_merged;
                        r_mem_wr    <= 1'b1;
                        r_state     <= S_WRITE;
                    end else begin
                        r_load_data <= w_load_lane;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wr     = r_mem_wr;
    assign mem_wdata  = r_mem_wdata;
    assign load_data  = r_load_data;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign misaligned = r_misaligned;

endmodule
